// File: rtl/led_pkg.sv
// Shared mode encoding for the LED pattern engine.
package led_pkg;

  typedef logic [1:0] mode_t;

  localparam mode_t MODE_COUNT   = 2'd0;
  localparam mode_t MODE_SCAN    = 2'd1;
  localparam mode_t MODE_BREATHE = 2'd2;
  localparam mode_t MODE_BLINK   = 2'd3;
  localparam mode_t MODE_LAST    = 2'd3;

  function automatic mode_t next_mode(input mode_t m);
    mode_t n;
    if (m == MODE_LAST) begin
      n = MODE_COUNT;
    end else begin
      n = m + 2'd1;
    end
    return n;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Button conditioner: 2-flop synchroniser followed by a stability counter.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_btn,
  output logic o_level,
  output logic o_rise
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1'b1);
  localparam logic [CW-1:0] CNT_ZERO = CW'(1'b0);

  logic          sync1_r;
  logic          sync2_r;
  logic          level_r;
  logic          rise_r;
  logic [CW-1:0] cnt_r;

  // Synchronise, then accept a new level once it has persisted long enough.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      sync1_r <= 1'b0;
      sync2_r <= 1'b0;
      level_r <= 1'b0;
      rise_r  <= 1'b0;
      cnt_r   <= CNT_ZERO;
    end else begin
      sync1_r <= i_btn;
      sync2_r <= sync1_r;
      if (sync2_r != level_r) begin
        if (cnt_r == CNT_LAST) begin
          level_r <= sync2_r;
          rise_r  <= sync2_r;
          cnt_r   <= CNT_ZERO;
        end else begin
          rise_r  <= 1'b0;
          cnt_r   <= cnt_r + CNT_ONE;
        end
      end else begin
        rise_r <= 1'b0;
        cnt_r  <= CNT_ZERO;
      end
    end
  end

  assign o_level = level_r;
  assign o_rise  = rise_r;

endmodule

// File: rtl/led_pattern_gen.sv
// LED pattern engine: mode FSM, step prescaler and four pattern generators.
module led_pattern_gen
  import led_pkg::*;
#(
  parameter int NUM_LEDS        = 8,
  parameter int TICK_DIV        = 1048576,
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int PWM_BITS        = 8
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_btn_mode,
  input  logic                i_btn_pause,
  output logic [NUM_LEDS-1:0] o_led,
  output logic [1:0]          o_mode,
  output logic                o_tick
);

  localparam int PRE_W = $clog2(TICK_DIV);
  localparam int POS_W = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;

  localparam logic [PRE_W-1:0]    PRE_LAST  = PRE_W'(TICK_DIV - 1);
  localparam logic [PRE_W-1:0]    PRE_ONE   = PRE_W'(1'b1);
  localparam logic [PRE_W-1:0]    PRE_ZERO  = PRE_W'(1'b0);
  localparam logic [POS_W-1:0]    POS_LAST  = POS_W'(NUM_LEDS - 1);
  localparam logic [POS_W-1:0]    POS_ONE   = POS_W'(1'b1);
  localparam logic [POS_W-1:0]    POS_ZERO  = POS_W'(1'b0);
  localparam logic [PWM_BITS-1:0] DUTY_MAX  = {PWM_BITS{1'b1}};
  localparam logic [PWM_BITS-1:0] DUTY_ONE  = PWM_BITS'(1'b1);
  localparam logic [PWM_BITS-1:0] DUTY_ZERO = PWM_BITS'(1'b0);
  localparam logic [NUM_LEDS-1:0] LED_ONE   = NUM_LEDS'(1'b1);
  localparam logic [NUM_LEDS-1:0] LED_ZERO  = NUM_LEDS'(1'b0);

  mode_t               mode_r;
  logic [PRE_W-1:0]    pre_r;
  logic [NUM_LEDS-1:0] step_r;
  logic [POS_W-1:0]    pos_r;
  logic                scan_down_r;
  logic [PWM_BITS-1:0] duty_r;
  logic                ramp_down_r;
  logic                toggle_r;
  logic [PWM_BITS-1:0] pwm_cnt_r;
  logic [NUM_LEDS-1:0] led_r;

  logic                mode_rise_s;
  logic                pause_s;
  logic                tick_s;
  logic [POS_W-1:0]    pos_next_s;
  logic                scan_down_next_s;
  logic [PWM_BITS-1:0] duty_next_s;
  logic                ramp_down_next_s;
  logic [NUM_LEDS-1:0] pattern_s;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_mode (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_btn   (i_btn_mode),
    .o_level (),
    .o_rise  (mode_rise_s)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_pause (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_btn   (i_btn_pause),
    .o_level (pause_s),
    .o_rise  ()
  );

  // A mode edge in the same cycle swallows the step pulse.
  assign tick_s = (pre_r == PRE_LAST) && !pause_s && !mode_rise_s;

  // Scan position and breathe duty both bounce off their end stops.
  always_comb begin
    pos_next_s       = pos_r;
    scan_down_next_s = scan_down_r;
    duty_next_s      = duty_r;
    ramp_down_next_s = ramp_down_r;
    if (NUM_LEDS == 1) begin
      pos_next_s = POS_ZERO;
    end else if (!scan_down_r) begin
      if (pos_r == POS_LAST) begin
        scan_down_next_s = 1'b1;
        pos_next_s       = pos_r - POS_ONE;
      end else begin
        pos_next_s = pos_r + POS_ONE;
      end
    end else begin
      if (pos_r == POS_ZERO) begin
        scan_down_next_s = 1'b0;
        pos_next_s       = POS_ONE;
      end else begin
        pos_next_s = pos_r - POS_ONE;
      end
    end
    if (!ramp_down_r) begin
      if (duty_r == DUTY_MAX) begin
        ramp_down_next_s = 1'b1;
        duty_next_s      = duty_r - DUTY_ONE;
      end else begin
        duty_next_s = duty_r + DUTY_ONE;
      end
    end else begin
      if (duty_r == DUTY_ZERO) begin
        ramp_down_next_s = 1'b0;
        duty_next_s      = DUTY_ONE;
      end else begin
        duty_next_s = duty_r - DUTY_ONE;
      end
    end
  end

  // Pattern decode from the current mode and its state.
  always_comb begin
    pattern_s = LED_ZERO;
    case (mode_r)
      MODE_COUNT:   pattern_s = step_r;
      MODE_SCAN:    pattern_s = LED_ONE << pos_r;
      MODE_BREATHE: pattern_s = {NUM_LEDS{pwm_cnt_r < duty_r}};
      MODE_BLINK:   pattern_s = {NUM_LEDS{toggle_r}};
      default:      pattern_s = LED_ZERO;
    endcase
  end

  // Mode FSM, prescaler, per-mode pattern state and the LED register.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      mode_r      <= MODE_COUNT;
      pre_r       <= PRE_ZERO;
      step_r      <= LED_ZERO;
      pos_r       <= POS_ZERO;
      scan_down_r <= 1'b0;
      duty_r      <= DUTY_ZERO;
      ramp_down_r <= 1'b0;
      toggle_r    <= 1'b0;
      pwm_cnt_r   <= DUTY_ZERO;
      led_r       <= LED_ZERO;
    end else begin
      pwm_cnt_r <= pwm_cnt_r + DUTY_ONE;
      led_r     <= pattern_s;
      if (mode_rise_s) begin
        mode_r      <= next_mode(mode_r);
        pre_r       <= PRE_ZERO;
        step_r      <= LED_ZERO;
        pos_r       <= POS_ZERO;
        scan_down_r <= 1'b0;
        duty_r      <= DUTY_ZERO;
        ramp_down_r <= 1'b0;
        toggle_r    <= 1'b0;
      end else if (tick_s) begin
        pre_r <= PRE_ZERO;
        case (mode_r)
          MODE_COUNT: step_r <= step_r + LED_ONE;
          MODE_SCAN: begin
            pos_r       <= pos_next_s;
            scan_down_r <= scan_down_next_s;
          end
          MODE_BREATHE: begin
            duty_r      <= duty_next_s;
            ramp_down_r <= ramp_down_next_s;
          end
          MODE_BLINK: toggle_r <= ~toggle_r;
          default:    toggle_r <= toggle_r;
        endcase
      end else if (!pause_s) begin
        pre_r <= pre_r + PRE_ONE;
      end else begin
        pre_r <= pre_r;
      end
    end
  end

  assign o_led  = led_r;
  assign o_mode = mode_r;
  assign o_tick = tick_s;

endmodule

// File: tb/tb_led_pattern_gen.sv
// Bench for led_pattern_gen: directed plus random button activity against a tick-count model.
module tb_led_pattern_gen;

  localparam int N       = 4;
  localparam int TD      = 4;
  localparam int D       = 3;
  localparam int PB      = 3;
  localparam int PWM_MOD = 1 << PB;
  localparam int DMAX    = PWM_MOD - 1;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         btn_mode;
  logic         btn_pause;
  logic [N-1:0] led;
  logic [1:0]   mode;
  logic         tick;

  always #5 clk = ~clk;

  led_pattern_gen #(
    .NUM_LEDS(N), .TICK_DIV(TD), .DEBOUNCE_CYCLES(D), .PWM_BITS(PB)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_btn_mode(btn_mode), .i_btn_pause(btn_pause),
    .o_led(led), .o_mode(mode), .o_tick(tick)
  );

  int errors = 0;
  int checks = 0;
  bit valid  = 0;
  bit bp_cur = 0;

  // Model: mode, unpaused cycles since last clear, free PWM count, and button histories.
  int           m_mode, m_run, m_pwm;
  logic [N-1:0] m_led;
  bit           m_rise;
  bit           m_s1[2], m_s2[2], m_acc[2];
  bit           hist[2][D];
  int           hn[2];

  // Pattern as a closed-form function of the number of completed steps.
  function automatic logic [N-1:0] pattern(input int md, input int t, input int pwm);
    int per, k, p;
    logic [N-1:0] r;
    r = '0;
    case (md)
      0: r = N'(t % (1 << N));
      1: begin
        if (N == 1) r = N'(1);
        else begin
          per = 2 * (N - 1);
          k = t % per;
          p = (k < N) ? k : per - k;
          r = N'(1 << p);
        end
      end
      2: begin
        per = 2 * DMAX;
        k = t % per;
        p = (k <= DMAX) ? k : per - k;
        r = (pwm < p) ? {N{1'b1}} : {N{1'b0}};
      end
      default: r = (t % 2 == 1) ? {N{1'b1}} : {N{1'b0}};
    endcase
    return r;
  endfunction

  task automatic model_edge(input bit r, input bit bm, input bit bp);
    bit in_b[2];
    bit pause, rise, all_diff, new_rise;
    logic [N-1:0] pat;
    if (!r) begin
      m_mode = 0; m_run = 0; m_pwm = 0; m_led = '0; m_rise = 0;
      for (int b = 0; b < 2; b++) begin
        m_s1[b] = 0; m_s2[b] = 0; m_acc[b] = 0; hn[b] = 0;
      end
    end else begin
      pat = pattern(m_mode, m_run / TD, m_pwm);
      pause = m_acc[1];
      rise = m_rise;
      new_rise = 0;
      in_b[0] = bm;
      in_b[1] = bp;
      for (int b = 0; b < 2; b++) begin
        for (int i = D - 1; i > 0; i--) hist[b][i] = hist[b][i-1];
        hist[b][0] = m_s2[b];
        if (hn[b] < D) hn[b]++;
        all_diff = (hn[b] == D);
        for (int i = 0; i < D; i++) if (hist[b][i] == m_acc[b]) all_diff = 0;
        if (all_diff) m_acc[b] = ~m_acc[b];
        if (b == 0 && all_diff && m_acc[0]) new_rise = 1;
        m_s2[b] = m_s1[b];
        m_s1[b] = in_b[b];
      end
      if (rise) begin
        m_mode = (m_mode + 1) % 4;
        m_run = 0;
      end else if (!pause) begin
        m_run++;
      end
      m_pwm = (m_pwm + 1) % PWM_MOD;
      m_led = pat;
      m_rise = new_rise;
    end
  endtask

  // One clock: drive inputs, check outputs of the current cycle, advance DUT and model.
  task automatic cyc(input bit r, input bit bm, input bit bp);
    bit et;
    rst_n = r; btn_mode = bm; btn_pause = bp;
    if (valid) begin
      et = ((m_run % TD) == TD - 1) && !m_acc[1] && !m_rise;
      checks++;
      assert (led === m_led) else begin
        errors++;
        $error("FAIL led observed=%b expected=%b t=%0t", led, m_led, $time);
      end
      checks++;
      assert (mode === 2'(m_mode)) else begin
        errors++;
        $error("FAIL mode observed=%0d expected=%0d t=%0t", mode, m_mode, $time);
      end
      checks++;
      assert (tick === et) else begin
        errors++;
        $error("FAIL tick observed=%b expected=%b t=%0t", tick, et, $time);
      end
    end
    @(posedge clk);
    model_edge(r, bm, bp);
    if (!r) valid = 1;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, bp_cur);
  endtask

  task automatic pulse_mode(input int len);
    for (int i = 0; i < len; i++) cyc(1'b1, 1'b1, bp_cur);
    idle(8);
  endtask

  task automatic do_reset();
    bp_cur = 0;
    cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    bit bm, bp, r;
    int guard;
    rst_n = 1'b0; btn_mode = 1'b0; btn_pause = 1'b0;

    // Free-running count after reset.
    do_reset();
    idle(82);

    // Clean mode press into SCAN, then short pulse and glitch train.
    pulse_mode(6);
    idle(34);
    pulse_mode(2);
    for (int i = 0; i < 12; i++) cyc(1'b1, (i % 3) != 2, 1'b0);
    for (int i = 0; i < 10; i++) cyc(1'b1, (i % 2) == 0, 1'b0);
    idle(10);

    // Pause in COUNT at value 5.
    do_reset();
    guard = 0;
    while (!(m_mode == 0 && m_led == 4'd5) && guard < 200) begin
      cyc(1'b1, 1'b0, 1'b0);
      guard++;
    end
    bp_cur = 1;
    idle(40);
    bp_cur = 0;
    idle(20);

    // Breathe: full duty ramp, plus a pause while breathing.
    do_reset();
    pulse_mode(4);
    pulse_mode(4);
    idle(70);
    bp_cur = 1;
    idle(20);
    bp_cur = 0;
    idle(10);

    // Mode edge at each prescaler phase.
    for (int off = 0; off < 4; off++) begin
      do_reset();
      idle(off);
      pulse_mode(5);
      idle(8);
    end

    // Reset mid-scan at position 2.
    do_reset();
    pulse_mode(5);
    guard = 0;
    while (!(m_mode == 1 && m_led == 4'b0100) && guard < 200) begin
      cyc(1'b1, 1'b0, 1'b0);
      guard++;
    end
    cyc(1'b0, 1'b0, 1'b0);
    idle(20);

    // Four edges wrap mode back to COUNT.
    for (int i = 0; i < 4; i++) begin
      pulse_mode(4);
      idle(6);
    end

    // Random button activity with occasional resets.
    bm = 0; bp = 0;
    for (int i = 0; i < 2000; i++) begin
      r = ($urandom_range(0, 499) != 0);
      if ($urandom_range(0, 7) == 0) bm = ~bm;
      if ($urandom_range(0, 15) == 0) bp = ~bp;
      cyc(r, bm, bp);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
